// File: rtl/core_if.sv
// core_if: instruction fetch stage.
// Generates the PC, fetches over an imem req/ack handshake, and buffers
// {addr, inst} pairs in a small FIFO for the decode side. Redirects flush
// the FIFO; a redirect that lands while a request is in flight drains that
// request before fetching at the new target.
// Optional feature macro: CORE_IF_MISALIGN_CHK_EN (misaligned-redirect
// detection with a HALT state). Without it, jump_addr_in[1:0] is ignored.
module core_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out,
    output logic        misalign_out
);

    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef CORE_IF_MISALIGN_CHK_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
`endif

    state_t          r_state;
    logic [31:0]     r_pc;       // address of the current/next fetch
    logic [31:0]     r_tgt;      // redirect target parked while draining
    logic            r_misalign;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [31:0]     r_fifo_addr [FIFO_DEPTH];
    logic [31:0]     r_fifo_inst [FIFO_DEPTH];

    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_mis;
    logic [31:0]     w_tgt;

`ifdef CORE_IF_MISALIGN_CHK_EN
    assign w_mis = |jump_addr_in[1:0];
    assign w_tgt = jump_addr_in;
`else
    // Low bits of the target are dropped: redirects are always word aligned.
    logic w_unused_jlo;
    assign w_unused_jlo = ^jump_addr_in[1:0];
    assign w_mis        = 1'b0;
    assign w_tgt        = {jump_addr_in[31:2], 2'b00};
`endif

    // Request while fetching with room in the FIFO; a drain keeps its request up.
    assign w_req   = ((r_state == S_FETCH) && (r_count < CW'(FIFO_DEPTH))) ||
                     (r_state == S_DRAIN);
    assign w_valid = (r_count != '0);
    assign w_push  = !jump_en_in && (r_state == S_FETCH) && w_req && imem_ack_in;
    assign w_pop   = !jump_en_in && w_valid && !hold_in;

    assign imem_req_out   = w_req;
    assign imem_addr_out  = r_pc;
    assign inst_valid_out = w_valid;
    assign inst_out       = w_valid ? r_fifo_inst[r_rd_ptr] : NOP;
    assign inst_addr_out  = w_valid ? r_fifo_addr[r_rd_ptr] : 32'h0;
    assign misalign_out   = r_misalign;

    // Fetch FSM and PC: redirects take priority over any handshake this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_tgt      <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (jump_en_in) begin
`ifdef CORE_IF_MISALIGN_CHK_EN
                if (w_mis) begin
                    r_misalign <= 1'b1;
                    r_state    <= S_HALT;
                end else
`endif
                if (w_req && !imem_ack_in) begin
                    // In-flight request must finish on the old address first.
                    r_tgt   <= w_tgt;
                    r_state <= S_DRAIN;
                end else begin
                    r_pc    <= w_tgt;
                    r_state <= S_FETCH;
                end
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= S_FETCH;
                    S_FETCH: if (w_req && imem_ack_in) r_pc <= r_pc + 32'd4;
                    S_DRAIN: if (imem_ack_in) begin
                                 r_pc    <= r_tgt;
                                 r_state <= S_FETCH;
                             end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || jump_en_in) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_pc;
            r_fifo_inst[r_wr_ptr] <= imem_data_in;
        end
    end

endmodule

// File: tb/tb_core_if.sv
// Directed bench for core_if: reset, streaming, hold/backpressure,
// redirect flush, redirect during a waited request, PC wrap, misalign.
module tb_core_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic        jump_en_in = 1'b0;
    logic [31:0] jump_addr_in = 32'h0;
    logic        hold_in = 1'b0;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;
    logic        misalign_out;

    logic zw  = 1'b1;   // zero-wait imem: ack follows req
    logic man = 1'b0;   // manual ack when zw = 0

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_ack_in  = zw ? imem_req_out : man;
    assign imem_data_in = ~imem_addr_out;

    core_if dut (
        .clk(clk), .rst(rst),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
        .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
        .hold_in(hold_in),
        .inst_valid_out(inst_valid_out), .inst_out(inst_out),
        .inst_addr_out(inst_addr_out), .misalign_out(misalign_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a);
        chk({tag, "_vld"},  {31'h0, inst_valid_out}, 32'h1);
        chk({tag, "_addr"}, inst_addr_out, a);
        chk({tag, "_inst"}, inst_out, ~a);
    endtask

    initial begin
        // Reset values
        step(); step();
        chk("rst_req",  {31'h0, imem_req_out}, 32'h0);
        chk("rst_addr", imem_addr_out, 32'h0);
        chk("rst_vld",  {31'h0, inst_valid_out}, 32'h0);
        chk("rst_inst", inst_out, 32'h0000_0013);
        chk("rst_iadr", inst_addr_out, 32'h0);
        chk("rst_mis",  {31'h0, misalign_out}, 32'h0);

        // Streaming: first valid two edges after reset release
        rst = 1'b0;
        step();
        chk("s1_req", {31'h0, imem_req_out}, 32'h1);
        chk("s1_vld", {31'h0, inst_valid_out}, 32'h0);
        step(); chk_head("s2", 32'h0);
        step(); chk_head("s3", 32'h4);
        step(); chk_head("s4", 32'h8);

        // Hold from reset: FIFO fills to 2, req drops, head stays 0x0
        rst = 1'b1; hold_in = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("h_req0", {31'h0, imem_req_out}, 32'h0);
        chk_head("h_a", 32'h0);
        step(); step();
        chk("h_req1", {31'h0, imem_req_out}, 32'h0);
        chk_head("h_b", 32'h0);
        hold_in = 1'b0;
        step(); chk_head("h_c", 32'h4);
        step(); chk_head("h_d", 32'h8);
        step(); chk_head("h_e", 32'hC);

        // Fill to 2 then redirect to 0x100
        hold_in = 1'b1;
        step();
        chk("f_req", {31'h0, imem_req_out}, 32'h0);
        jump_en_in = 1'b1; jump_addr_in = 32'h100;
        step();
        jump_en_in = 1'b0; hold_in = 1'b0;
        chk("j_vld",  {31'h0, inst_valid_out}, 32'h0);
        chk("j_addr", imem_addr_out, 32'h100);
        step(); chk_head("j_a", 32'h100);
        step(); chk_head("j_b", 32'h104);

        // Waited imem, redirect to 0x200 in the first wait cycle
        zw = 1'b0; man = 1'b0;
        jump_en_in = 1'b1; jump_addr_in = 32'h200;
        step();
        jump_en_in = 1'b0;
        chk("d_req0", {31'h0, imem_req_out}, 32'h1);
        chk("d_addr0", imem_addr_out, 32'h108);
        chk("d_vld0", {31'h0, inst_valid_out}, 32'h0);
        step();
        chk("d_addr1", imem_addr_out, 32'h108);
        man = 1'b1;
        step();
        man = 1'b0;
        chk("d_vld2",  {31'h0, inst_valid_out}, 32'h0);
        chk("d_addr2", imem_addr_out, 32'h200);
        chk("d_req2",  {31'h0, imem_req_out}, 32'h1);
        zw = 1'b1;
        step(); chk_head("d_a", 32'h200);

        // Redirect with ack in the same cycle, then PC wrap
        jump_en_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
        step();
        jump_en_in = 1'b0;
        chk("w_addr0", imem_addr_out, 32'hFFFF_FFFC);
        chk("w_vld0", {31'h0, inst_valid_out}, 32'h0);
        step();
        chk_head("w_a", 32'hFFFF_FFFC);
        chk("w_addr1", imem_addr_out, 32'h0);
        step(); chk_head("w_b", 32'h0);

`ifdef CORE_IF_MISALIGN_CHK_EN
        // Misaligned redirect halts; aligned redirect resumes
        jump_en_in = 1'b1; jump_addr_in = 32'h102;
        step();
        jump_en_in = 1'b0;
        chk("m_mis1", {31'h0, misalign_out}, 32'h1);
        chk("m_req1", {31'h0, imem_req_out}, 32'h0);
        chk("m_vld1", {31'h0, inst_valid_out}, 32'h0);
        step();
        chk("m_mis2", {31'h0, misalign_out}, 32'h0);
        chk("m_req2", {31'h0, imem_req_out}, 32'h0);
        jump_en_in = 1'b1; jump_addr_in = 32'h104;
        step();
        jump_en_in = 1'b0;
        chk("m_req3",  {31'h0, imem_req_out}, 32'h1);
        chk("m_addr3", imem_addr_out, 32'h104);
        step(); chk_head("m_a", 32'h104);
`else
        // Without the check, low target bits are dropped silently
        jump_en_in = 1'b1; jump_addr_in = 32'h102;
        step();
        jump_en_in = 1'b0;
        chk("m_mis",  {31'h0, misalign_out}, 32'h0);
        chk("m_addr", imem_addr_out, 32'h100);
        step(); chk_head("m_a", 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
